// File: rtl/gate_truth_table_sequencer.sv
// Truth-table checker for one N-input combinational gate: sweeps every input vector,
// waits a settle window, samples the gate output and flags per-vector mismatches.
`timescale 1ns/1ps

module gate_truth_table_sequencer #(
  parameter int                     N_IN          = 2,
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [(2**N_IN)-1:0]   EXPECTED      = 4'b0111
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      gate_out,
  output logic [N_IN-1:0]           gate_in,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [(2**N_IN)-1:0]      mismatch
);

  localparam int V  = 2**N_IN;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(V - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t            state, state_d;
  logic [N_IN-1:0]   vec, vec_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [N_IN-1:0]   gate_in_d;
  logic              busy_d, done_d, pass_d;
  logic [V-1:0]      mismatch_d;

  // State and every registered output update together; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      vec      <= '0;
      cnt      <= '0;
      gate_in  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mismatch <= '0;
    end else begin
      state    <= state_d;
      vec      <= vec_d;
      cnt      <= cnt_d;
      gate_in  <= gate_in_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      mismatch <= mismatch_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt == CNT_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (vec == VEC_LAST) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // PASS is taken from the post-sample mismatch vector so the last vector counts.
  always_comb begin
    vec_d      = vec;
    cnt_d      = cnt;
    gate_in_d  = gate_in;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    mismatch_d = mismatch;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          vec_d      = '0;
          cnt_d      = '0;
          gate_in_d  = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          mismatch_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt != CNT_LAST) cnt_d = cnt + 1'b1;
      end
      ST_SAMPLE: begin
        mismatch_d[vec] = mismatch[vec] | (gate_out != EXPECTED[vec]);
        if (vec == VEC_LAST) begin
          done_d = 1'b1;
          pass_d = (mismatch_d == '0);
        end else begin
          vec_d     = vec + 1'b1;
          gate_in_d = vec + 1'b1;
          cnt_d     = '0;
        end
      end
      ST_DONE: begin
        gate_in_d = '0;
        busy_d    = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Scoreboard bench: a default NAND checker and a 3-input XOR checker, each driven
// against behavioural gate models with selectable faults.
`timescale 1ns/1ps

module tb_gate_truth_table_sequencer;

  localparam logic [3:0] EXP2 = 4'b0111;
  localparam logic [7:0] EXP3 = 8'h96;

  typedef struct {
    int         t;
    logic [7:0] mismatch;
    logic       pass;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start2 = 1'b0, start3 = 1'b0;
  logic       gate_out2, gate_out3;
  logic [1:0] gate_in2;
  logic [2:0] gate_in3;
  logic       busy2, busy3, done2, done3, pass2, pass3;
  logic [3:0] mismatch2;
  logic [7:0] mismatch3;

  int  mode = 0;
  bit  sel = 1'b0;
  int  cyc = 0;
  int  errCount = 0;
  int  checkCount = 0;
  sb_t q[$];

  logic [2:0] mon_gate_in;
  logic       mon_busy, mon_done, mon_pass;
  logic [7:0] mon_mismatch;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_truth_table_sequencer dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_out(gate_out2),
    .gate_in(gate_in2), .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2)
  );

  gate_truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h96)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .gate_out(gate_out3),
    .gate_in(gate_in3), .busy(busy3), .done(done3), .pass(pass3), .mismatch(mismatch3)
  );

  // Mode 0 NAND, 1 AND, 2 NAND stuck-high on vector 3; for the 3-input gate, 3 = XNOR else XOR.
  function automatic logic gateModel(input bit s, input int m, input logic [2:0] k);
    if (s) return (m == 3) ? ~^k : ^k;
    case (m)
      1:       return k[1] & k[0];
      2:       return (k[1:0] == 2'd3) ? 1'b1 : ~(k[1] & k[0]);
      default: return ~(k[1] & k[0]);
    endcase
  endfunction

  function automatic logic [7:0] expMismatch(input bit s, input int m);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < (s ? 8 : 4); k++) begin
      if (s) r[k] = gateModel(s, m, 3'(k)) != EXP3[k];
      else   r[k] = gateModel(s, m, 3'(k)) != EXP2[k];
    end
    return r;
  endfunction

  assign gate_out2    = gateModel(1'b0, mode, {1'b0, gate_in2});
  assign gate_out3    = gateModel(1'b1, mode, gate_in3);
  assign mon_gate_in  = sel ? gate_in3 : {1'b0, gate_in2};
  assign mon_busy     = sel ? busy3 : busy2;
  assign mon_done     = sel ? done3 : done2;
  assign mon_pass     = sel ? pass3 : pass2;
  assign mon_mismatch = sel ? mismatch3 : {4'b0, mismatch2};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checkCount++;
    if (got !== expected) begin
      errCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, expected, cyc);
    end
  endtask

  task automatic pushExpected(input bit s, input int m);
    sb_t e;
    e.t        = cyc + 1;
    e.mismatch = expMismatch(s, m);
    e.pass     = (e.mismatch == 8'h00);
    q.push_back(e);
  endtask

  task automatic applyStimulus(input bit s, input int m);
    @(posedge clk); #2;
    sel  = s;
    mode = m;
    pushExpected(s, m);
    if (s) start3 = 1'b1;
    else   start2 = 1'b1;
    @(posedge clk); #2;
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic waitDone();
    int i;
    i = 0;
    while (q.size() != 0 && i < 200) begin
      @(posedge clk); #2;
      i++;
    end
    if (q.size() != 0) begin
      checkOutput("done_timeout", 32'd1, 32'd0);
      q.delete();
    end
  endtask

  task automatic checkIdle2(input string tag);
    checkOutput({tag, "_gate_in"}, 32'(gate_in2), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy2), 32'd0);
    checkOutput({tag, "_done"}, 32'(done2), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass2), 32'd0);
    checkOutput({tag, "_mismatch"}, 32'(mismatch2), 32'd0);
  endtask

  // Per-cycle drive/busy checks during a sweep, and result checks when DONE pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0) begin
        int span, hold;
        sb_t e;
        e    = q[0];
        hold = sel ? 2 : 3;
        span = (sel ? 8 : 4) * hold;
        if (cyc >= e.t && cyc < e.t + span) begin
          checkOutput("gate_in", 32'(mon_gate_in), 32'((cyc - e.t) / hold));
          checkOutput("busy", 32'(mon_busy), 32'd1);
        end
        if (mon_done) begin
          checkOutput("done_latency", 32'(cyc + 1 - e.t), 32'(span + 1));
          checkOutput("mismatch", 32'(mon_mismatch), 32'(e.mismatch));
          checkOutput("pass", 32'(mon_pass), 32'(e.pass));
          checkOutput("busy_at_done", 32'(mon_busy), 32'd1);
          void'(q.pop_front());
        end
      end else if (mon_done) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    checkIdle2("reset2");
    checkOutput("reset3_busy", 32'(busy3), 32'd0);
    checkOutput("reset3_mismatch", 32'(mismatch3), 32'd0);
    rst = 1'b0;

    $display("[TB] NAND sweep");
    applyStimulus(1'b0, 0);
    waitDone();

    $display("[TB] AND gate against NAND table");
    applyStimulus(1'b0, 1);
    waitDone();

    $display("[TB] NAND stuck-high on vector 3");
    applyStimulus(1'b0, 2);
    waitDone();

    $display("[TB] reset mid-sweep");
    applyStimulus(1'b0, 1);
    repeat (4) begin @(posedge clk); #2; end
    rst = 1'b1;
    q.delete();
    @(posedge clk); #2;
    checkIdle2("abort");
    rst = 1'b0;
    applyStimulus(1'b0, 0);
    waitDone();

    $display("[TB] START re-pulsed while busy");
    applyStimulus(1'b0, 2);
    repeat (3) begin @(posedge clk); #2; end
    start2 = 1'b1;
    @(posedge clk); #2;
    start2 = 1'b0;
    waitDone();
    repeat (2) begin @(posedge clk); #2; end
    checkOutput("no_requeue_busy", 32'(busy2), 32'd0);

    $display("[TB] START held high");
    @(posedge clk); #2;
    sel  = 1'b0;
    mode = 0;
    pushExpected(1'b0, 0);
    start2 = 1'b1;
    waitDone();
    checkOutput("held_gap_busy", 32'(busy2), 32'd0);
    pushExpected(1'b0, 0);
    @(posedge clk); #2;
    checkOutput("held_rebusy", 32'(busy2), 32'd1);
    start2 = 1'b0;
    waitDone();

    $display("[TB] START with RST");
    @(posedge clk); #2;
    rst    = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #2;
    checkOutput("rst_wins_busy", 32'(busy2), 32'd0);
    rst    = 1'b0;
    start2 = 1'b0;
    @(posedge clk); #2;
    checkOutput("rst_wins_idle", 32'(busy2), 32'd0);

    $display("[TB] 3-input XOR and XNOR");
    applyStimulus(1'b1, 0);
    waitDone();
    applyStimulus(1'b1, 3);
    waitDone();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
